// File: rtl/wb_random_slave.sv
// rtl/wb_random_slave.sv - Wishbone classic slave with LFSR read data, random wait and write checksum
// Optional feature macro: WB_RANDOM_SLAVE_ERR_INJECT_EN (err response for ERR_BASE..ERR_LIMIT)
module wb_random_slave #(
    parameter logic [31:0] SEED      = 32'h00000001,
    parameter logic [7:0]  WAIT_MASK = 8'h0F,
    parameter logic [31:0] ERR_BASE  = 32'hFFFF0000,
    parameter logic [31:0] ERR_LIMIT = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  i_wb_adr,
    input  logic [15:0]  i_wb_sel,
    input  logic         i_wb_we,
    input  logic [127:0] i_wb_dat,
    input  logic         i_wb_cyc,
    input  logic         i_wb_stb,
    output logic [127:0] o_wb_dat,
    output logic         o_wb_ack,
    output logic         o_wb_err,
    output logic [127:0] o_wr_checksum,
    output logic [31:0]  o_rd_count,
    output logic [31:0]  o_wr_count
);

    localparam logic [31:0] TAPS     = 32'h80200003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state, state_d;

    logic [31:0]  lane [4];
    logic [7:0]   wcnt, wcnt_d, wcnt_init;
    logic         accept;
    logic         addr_hit;
    logic         req_we, req_err;
    logic [15:0]  req_sel;
    logic [127:0] req_dat;
    logic         cur_we, cur_err;
    logic         ack_d, err_d;
    logic [127:0] dat_d;
    logic [127:0] rd_vec;
    logic [127:0] byte_mask;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

`ifdef WB_RANDOM_SLAVE_ERR_INJECT_EN
    assign addr_hit = (i_wb_adr >= ERR_BASE) && (i_wb_adr <= ERR_LIMIT);
`else
    logic unused_err_cfg;
    assign unused_err_cfg = ^{ERR_BASE, ERR_LIMIT, i_wb_adr};
    assign addr_hit       = 1'b0;
`endif

    assign accept    = (state == IDLE) && i_wb_cyc && i_wb_stb;
    assign wcnt_init = lane[0][7:0] & WAIT_MASK;
    assign rd_vec    = {lane[3], lane[2], lane[1], lane[0]};

    // Request attributes as seen by the output stage: live bus on the accept edge, latched otherwise
    assign cur_we  = accept ? i_wb_we  : req_we;
    assign cur_err = accept ? addr_hit : req_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wcnt  <= 8'h00;
        end else begin
            state <= state_d;
            wcnt  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    wcnt_d  = wcnt_init;
                    state_d = (wcnt_init == 8'h00) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt - 8'h01;
                    if (wcnt == 8'h01) begin
                        state_d = ACK;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d = 1'b0;
        err_d = 1'b0;
        dat_d = '0;
        if (state_d == ACK) begin
            ack_d = !cur_err;
            err_d = cur_err;
            if (!cur_we && !cur_err) begin
                dat_d = rd_vec;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            o_wb_ack <= ack_d;
            o_wb_err <= err_d;
            o_wb_dat <= dat_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_we  <= 1'b0;
            req_err <= 1'b0;
            req_sel <= '0;
            req_dat <= '0;
        end else if (accept) begin
            req_we  <= i_wb_we;
            req_err <= addr_hit;
            req_sel <= i_wb_sel;
            req_dat <= i_wb_dat;
        end
    end

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 16; i++) begin
            byte_mask[8*i +: 8] = {8{req_sel[i]}};
        end
    end

    // Side effects land at the end of the ACK cycle so an abort or reset earlier leaves nothing behind
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane[0]       <= SEED_EFF;
            lane[1]       <= {SEED_EFF[23:0], SEED_EFF[31:24]};
            lane[2]       <= {SEED_EFF[15:0], SEED_EFF[31:16]};
            lane[3]       <= {SEED_EFF[7:0],  SEED_EFF[31:8]};
            o_wr_checksum <= '0;
            o_rd_count    <= 32'h0;
            o_wr_count    <= 32'h0;
        end else if ((state == ACK) && !req_err) begin
            if (req_we) begin
                o_wr_checksum <= o_wr_checksum ^ (req_dat & byte_mask);
                o_wr_count    <= o_wr_count + 32'h1;
            end else begin
                o_rd_count <= o_rd_count + 32'h1;
                for (int i = 0; i < 4; i++) begin
                    lane[i] <= lfsr_step(lane[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_random_slave.sv
// tb/tb_wb_random_slave.sv - scoreboard bench for wb_random_slave (two parameter sets)
module tb_wb_random_slave;

    typedef struct packed {
        logic         err;
        logic [127:0] dat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst   [2];
    logic [31:0]  adr   [2];
    logic [15:0]  sel   [2];
    logic         we    [2];
    logic [127:0] wdat  [2];
    logic         cyc   [2];
    logic         stb   [2];
    logic [127:0] rdat  [2];
    logic         ack   [2];
    logic         err   [2];
    logic [127:0] csum  [2];
    logic [31:0]  rdcnt [2];
    logic [31:0]  wrcnt [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] A_V0 = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] A_V1 = 128'h00800000_00008000_00000080_80200003;
    localparam logic [127:0] A_V2 = 128'h00400000_00004000_00000040_C0300002;
    localparam logic [127:0] B_V0 = 128'h0F000000_000F0000_00000F00_0000000F;
    localparam logic [127:0] B_V1 = 128'h07800000_00078000_00000780_80200004;

    always #5 clk = ~clk;

    wb_random_slave #(.SEED(32'h00000001), .WAIT_MASK(8'h00)) dut_a (
        .clk(clk), .reset(rst[0]), .i_wb_adr(adr[0]), .i_wb_sel(sel[0]), .i_wb_we(we[0]),
        .i_wb_dat(wdat[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .o_wb_dat(rdat[0]),
        .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wr_checksum(csum[0]),
        .o_rd_count(rdcnt[0]), .o_wr_count(wrcnt[0]));

    wb_random_slave #(.SEED(32'h0000000F), .WAIT_MASK(8'h0F)) dut_b (
        .clk(clk), .reset(rst[1]), .i_wb_adr(adr[1]), .i_wb_sel(sel[1]), .i_wb_we(we[1]),
        .i_wb_dat(wdat[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .o_wb_dat(rdat[1]),
        .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wr_checksum(csum[1]),
        .o_rd_count(rdcnt[1]), .o_wr_count(wrcnt[1]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int k);
        exp_t e;
        if (ack[k] && err[k]) begin
            chk($sformatf("ack_err_excl[%0d]", k), 128'd1, 128'd0);
        end
        if (ack[k] || err[k]) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_resp[%0d]", k), 128'd1, 128'd0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("resp_err[%0d]", k), {127'd0, err[k]}, {127'd0, e.err});
                chk($sformatf("resp_dat[%0d]", k), rdat[k], e.dat);
            end
        end else begin
            chk($sformatf("idle_dat[%0d]", k), rdat[k], 128'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst[0]) mon(0);
        if (rst[1]) mon(1);
    end

    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [15:0] s,
                          input logic [127:0] d, input logic exp_err, input logic [127:0] exp_dat,
                          input int exp_lat);
        int n;
        bit got;
        exp_t e;
        e.err = exp_err;
        e.dat = exp_dat;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        adr[k] = a; sel[k] = s; we[k] = w; wdat[k] = d;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 64) begin
            @(posedge clk); #1;
            n++;
            if (ack[k] || err[k]) got = 1;
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        chk($sformatf("latency[%0d]", k), n, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; adr[k] = '0; sel[k] = '0; we[k] = 1'b0;
            wdat[k] = '0; cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        idle_cycles(3);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ack", {127'd0, ack[k]}, 128'd0);
            chk("reset_err", {127'd0, err[k]}, 128'd0);
            chk("reset_dat", rdat[k], 128'd0);
            chk("reset_csum", csum[k], 128'd0);
            chk("reset_rdcnt", rdcnt[k], 128'd0);
            chk("reset_wrcnt", wrcnt[k], 128'd0);
        end
        rst[0] = 1'b1; rst[1] = 1'b1;
        idle_cycles(2);

        // cyc without stb does nothing
        cyc[0] = 1'b1;
        idle_cycles(5);
        cyc[0] = 1'b0;
        idle_cycles(1);
        chk("nostb_rdcnt", rdcnt[0], 128'd0);

        // masked writes, LFSR must not move
        do_req(0, 1'b1, 32'h0, 16'h000F, {16{8'hAA}}, 1'b0, 128'd0, 1);
        do_req(0, 1'b1, 32'h4, 16'h0003, {16{8'hFF}}, 1'b0, 128'd0, 1);
        chk("wr_checksum", csum[0], 128'h00000000_00000000_00000000_AAAA5555);
        chk("wr_count2", wrcnt[0], 128'd2);
        chk("rd_count_after_wr", rdcnt[0], 128'd0);

        do_req(0, 1'b0, 32'h0, 16'hFFFF, 128'd0, 1'b0, A_V0, 1);
        chk("rd_count1", rdcnt[0], 128'd1);
        do_req(0, 1'b0, 32'h10, 16'hFFFF, 128'd0, 1'b0, A_V1, 1);
        chk("rd_count2", rdcnt[0], 128'd2);

        do_req(0, 1'b1, 32'h20, 16'h0000, {128{1'b1}}, 1'b0, 128'd0, 1);
        chk("sel0_checksum", csum[0], 128'h00000000_00000000_00000000_AAAA5555);
        chk("sel0_wr_count", wrcnt[0], 128'd3);

`ifdef WB_RANDOM_SLAVE_ERR_INJECT_EN
        do_req(0, 1'b0, 32'hFFFF0010, 16'hFFFF, 128'd0, 1'b1, 128'd0, 1);
        chk("err_rd_count", rdcnt[0], 128'd2);
        do_req(0, 1'b0, 32'hFFFEFFF0, 16'hFFFF, 128'd0, 1'b0, A_V2, 1);
        chk("below_err_rd_count", rdcnt[0], 128'd3);
`else
        do_req(0, 1'b0, 32'hFFFF0010, 16'hFFFF, 128'd0, 1'b0, A_V2, 1);
        chk("high_adr_rd_count", rdcnt[0], 128'd3);
`endif

        // abort during a 15-cycle wait
        adr[1] = 32'h0; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        idle_cycles(3);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        idle_cycles(20);
        chk("abort_rd_count", rdcnt[1], 128'd0);
        chk("abort_wr_count", wrcnt[1], 128'd0);

        do_req(1, 1'b0, 32'h0, 16'hFFFF, 128'd0, 1'b0, B_V0, 16);
        do_req(1, 1'b0, 32'h0, 16'hFFFF, 128'd0, 1'b0, B_V1, 5);
        chk("b_rd_count", rdcnt[1], 128'd2);

        // async reset during a wait wipes everything
        cyc[1] = 1'b1; stb[1] = 1'b1;
        idle_cycles(1);
        rst[1] = 1'b0;
        #1;
        chk("rst_mid_ack", {127'd0, ack[1]}, 128'd0);
        chk("rst_mid_rdcnt", rdcnt[1], 128'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        idle_cycles(1);
        rst[1] = 1'b1;
        idle_cycles(1);
        do_req(1, 1'b0, 32'h0, 16'hFFFF, 128'd0, 1'b0, B_V0, 16);
        chk("post_rst_rd_count", rdcnt[1], 128'd1);

        idle_cycles(3);
        chk("q0_drained", q0.size(), 128'd0);
        chk("q1_drained", q1.size(), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
